blink_top: RTL and testbench

Board-level bring-up block for the ECP5-Mini, running from the 16 MHz oscillator. It provides:
- a free-running heartbeat on the user LED;
- a synchronised, debounced user button that drives the activity LED;
- an 8-bit press counter on the LED bar;
- a PWM "breathing" RGB LED whose colour advances on each button press.

It is the top level of the blink design and connects directly to pins.

---
 rtl/blink_pkg.sv | 42 ++++
 rtl/btn_debounce.sv | 55 +++++
 rtl/blink_top.sv | 87 ++++++++
 tb/tb_blink_top.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/blink_pkg.sv
// Shared types and widths for the ECP5-Mini bring-up blink design.
`timescale 1ns/1ps
package blink_pkg;

    localparam int unsigned CNT_W = 24;
    localparam int unsigned PWM_W = 8;

    typedef enum logic [1:0] {
        ColRed,
        ColGreen,
        ColBlue,
        ColWhite
    } colour_e;

    function automatic colour_e next_colour(input colour_e c);
        colour_e n;
        n = ColRed;
        unique case (c)
            ColRed:   n = ColGreen;
            ColGreen: n = ColBlue;
            ColBlue:  n = ColWhite;
            ColWhite: n = ColRed;
            default:  n = ColRed;
        endcase
        return n;
    endfunction

    // Channel enables packed as {r, g, b}.
    function automatic logic [2:0] colour_enables(input colour_e c);
        logic [2:0] en;
        en = 3'b000;
        unique case (c)
            ColRed:   en = 3'b100;
            ColGreen: en = 3'b010;
            ColBlue:  en = 3'b001;
            ColWhite: en = 3'b111;
            default:  en = 3'b000;
        endcase
        return en;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser, counting debouncer and press (1->0) edge detector
// for an active-low push button.
`timescale 1ns/1ps
module btn_debounce
    import blink_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 65536
) (
    input  logic clk_16mhz,
    input  logic rst,
    input  logic btn_in,
    output logic btn_db,
    output logic press_pulse
);

    localparam int unsigned DBC_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DBC_W-1:0] DBC_LAST = DBC_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_btn_s;
    logic             r_btn_db;
    logic             r_press;
    logic [DBC_W-1:0] r_dbc;
    logic             w_mismatch;

    assign w_mismatch = (r_btn_s != r_btn_db);

    // Any matching sample restarts the count, so short glitches never get accepted.
    always_ff @(posedge clk_16mhz or posedge rst) begin
        if (rst) begin
            r_sync1  <= 1'b1;
            r_btn_s  <= 1'b1;
            r_btn_db <= 1'b1;
            r_press  <= 1'b0;
            r_dbc    <= '0;
        end else begin
            r_sync1 <= btn_in;
            r_btn_s <= r_sync1;
            r_press <= 1'b0;
            if (!w_mismatch) begin
                r_dbc <= '0;
            end else if (r_dbc == DBC_LAST) begin
                r_btn_db <= r_btn_s;
                r_dbc    <= '0;
                r_press  <= ~r_btn_s;
            end else begin
                r_dbc <= r_dbc + 1'b1;
            end
        end
    end

    assign btn_db      = r_btn_db;
    assign press_pulse = r_press;

endmodule

// File: rtl/blink_top.sv
// Board bring-up top: heartbeat LED, debounced button, press counter and a
// breathing PWM RGB LED whose colour steps on each press.
`timescale 1ns/1ps
module blink_top
    import blink_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 65536,
    parameter int unsigned BLINK_BIT       = 23,
    parameter int unsigned BREATH_BIT      = 21
) (
    input  logic       clk_16mhz,
    input  logic       rst,
    input  logic       btn_usr,
    output logic       led_usr,
    output logic       led_act,
    output logic       led_r,
    output logic       led_g,
    output logic       led_b,
    output logic [7:0] led
);

    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_press_cnt;
    colour_e          r_colour;
    logic             r_led_r;
    logic             r_led_g;
    logic             r_led_b;

    logic             w_btn_db;
    logic             w_press;
    logic [PWM_W-1:0] w_raw;
    logic [PWM_W-1:0] w_bright;
    logic             w_on;
    logic [2:0]       w_en;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk_16mhz  (clk_16mhz),
        .rst        (rst),
        .btn_in     (btn_usr),
        .btn_db     (w_btn_db),
        .press_pulse(w_press)
    );

    always_ff @(posedge clk_16mhz or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_press_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
            if (w_press) begin
                r_press_cnt <= r_press_cnt + 1'b1;
            end
        end
    end

    // Mirroring the brightness field on alternate half-periods gives a triangle wave.
    assign w_raw    = r_cnt[BREATH_BIT -: PWM_W];
    assign w_bright = r_cnt[BREATH_BIT + 1] ? ~w_raw : w_raw;
    assign w_on     = (r_cnt[PWM_W-1:0] < w_bright);
    assign w_en     = colour_enables(r_colour);

    always_ff @(posedge clk_16mhz or posedge rst) begin
        if (rst) begin
            r_colour <= ColRed;
            r_led_r  <= 1'b0;
            r_led_g  <= 1'b0;
            r_led_b  <= 1'b0;
        end else begin
            if (w_press) begin
                r_colour <= next_colour(r_colour);
            end
            r_led_r <= w_en[2] & w_on;
            r_led_g <= w_en[1] & w_on;
            r_led_b <= w_en[0] & w_on;
        end
    end

    assign led_usr = r_cnt[BLINK_BIT];
    assign led_act = ~w_btn_db;
    assign led_r   = r_led_r;
    assign led_g   = r_led_g;
    assign led_b   = r_led_b;
    assign led     = r_press_cnt;

endmodule

// File: tb/tb_blink_top.sv
// Directed bench for blink_top with short debounce and fast heartbeat/breath parameters.
`timescale 1ns/1ps
module tb_blink_top;

    localparam int unsigned DEB    = 16;
    localparam int unsigned BLINK  = 10;
    localparam int unsigned BREATH = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_usr = 1'b1;
    logic       led_usr;
    logic       led_act;
    logic       led_r;
    logic       led_g;
    logic       led_b;
    logic [7:0] led;

    int         checks = 0;
    int         failures = 0;
    logic [23:0] n_q;
    int         exp_col = 0;
    logic [7:0] exp_led = 8'h00;

    always #5 clk = ~clk;

    // Edges since reset release; equals the DUT heartbeat count by definition.
    always @(posedge clk or posedge rst) begin
        if (rst) n_q <= '0;
        else     n_q <= n_q + 1'b1;
    end

    blink_top #(
        .DEBOUNCE_CYCLES(DEB),
        .BLINK_BIT      (BLINK),
        .BREATH_BIT     (BREATH)
    ) dut (
        .clk_16mhz(clk),
        .rst      (rst),
        .btn_usr  (btn_usr),
        .led_usr  (led_usr),
        .led_act  (led_act),
        .led_r    (led_r),
        .led_g    (led_g),
        .led_b    (led_b),
        .led      (led)
    );

    // Expected {r,g,b} sampled after edge n, produced from the count before that edge.
    function automatic logic [2:0] exp_rgb(input logic [23:0] n, input int col);
        logic [23:0] c;
        logic [7:0]  raw;
        logic [7:0]  bright;
        logic [2:0]  en;
        if (n == 24'd0) return 3'b000;
        c      = n - 24'd1;
        raw    = c[15:8];
        bright = c[16] ? ~raw : raw;
        case (col)
            0:       en = 3'b100;
            1:       en = 3'b010;
            2:       en = 3'b001;
            default: en = 3'b111;
        endcase
        return (c[7:0] < bright) ? en : 3'b000;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press_release();
        btn_usr = 1'b0;
        repeat (20) step();
        btn_usr = 1'b1;
        repeat (20) step();
        exp_led = exp_led + 8'd1;
        exp_col = (exp_col + 1) % 4;
    endtask

    task automatic test_reset();
        repeat (3) step();
        rst = 1'b0;
        repeat (1100) step();
        press_release();
        checks++;
        if (led !== 8'h01) begin
            failures++;
            $display("FAIL reset_pre_led: got %0h expected 01", led);
        end
        btn_usr = 1'b0;
        repeat (20) step();
        checks++;
        if (led_act !== 1'b1 || led_usr !== 1'b1) begin
            failures++;
            $display("FAIL reset_pre_act: got act=%0b usr=%0b expected act=1 usr=1", led_act, led_usr);
        end
        #3 rst = 1'b1;
        #1;
        checks++;
        if ({led_usr, led_act, led_r, led_g, led_b, led} !== 13'd0) begin
            failures++;
            $display("FAIL reset_async_outputs: got usr=%0b act=%0b rgb=%0b%0b%0b led=%0h expected all 0",
                     led_usr, led_act, led_r, led_g, led_b, led);
        end
        btn_usr = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        exp_led = 8'h00;
        exp_col = 0;
        repeat (25) step();
        checks++;
        if (led !== 8'h00 || led_act !== 1'b0) begin
            failures++;
            $display("FAIL reset_after_release: got led=%0h act=%0b expected led=00 act=0", led, led_act);
        end
        for (int i = 0; i < 600; i++) begin
            step();
            checks++;
            if ({led_r, led_g, led_b} !== exp_rgb(n_q, exp_col)) begin
                failures++;
                $display("FAIL reset_rgb_red n=%0d: got %b expected %b",
                         n_q, {led_r, led_g, led_b}, exp_rgb(n_q, exp_col));
            end
        end
    endtask

    task automatic test_bounce();
        for (int r = 0; r < 10; r++) begin
            btn_usr = 1'b0;
            repeat (15) step();
            btn_usr = 1'b1;
            repeat (4) step();
            checks++;
            if (led_act !== 1'b0) begin
                failures++;
                $display("FAIL bounce_act rep=%0d: got %0b expected 0", r, led_act);
            end
        end
        repeat (20) step();
        checks++;
        if (led !== 8'h00 || led_act !== 1'b0) begin
            failures++;
            $display("FAIL bounce_final: got led=%0h act=%0b expected led=00 act=0", led, led_act);
        end
    endtask

    task automatic test_clean_press();
        logic [7:0] old;
        old = exp_led;
        btn_usr = 1'b0;
        for (int j = 1; j <= 19; j++) begin
            step();
            if (j == 17) begin
                checks++;
                if (led_act !== 1'b0) begin
                    failures++;
                    $display("FAIL press_act_early k+17: got %0b expected 0", led_act);
                end
            end
            if (j == 18) begin
                checks++;
                if (led_act !== 1'b1 || led !== old) begin
                    failures++;
                    $display("FAIL press_act k+18: got act=%0b led=%0h expected act=1 led=%0h",
                             led_act, led, old);
                end
            end
            if (j == 19) begin
                checks++;
                if (led !== old + 8'd1) begin
                    failures++;
                    $display("FAIL press_led k+19: got %0h expected %0h", led, old + 8'd1);
                end
            end
        end
        exp_led = old + 8'd1;
        exp_col = (exp_col + 1) % 4;
        for (int i = 0; i < 300; i++) begin
            step();
            checks++;
            if ({led_r, led_g, led_b} !== exp_rgb(n_q, exp_col)) begin
                failures++;
                $display("FAIL press_rgb_green n=%0d: got %b expected %b",
                         n_q, {led_r, led_g, led_b}, exp_rgb(n_q, exp_col));
            end
        end
        btn_usr = 1'b1;
        repeat (20) step();
        checks++;
        if (led_act !== 1'b0 || led !== 8'h01) begin
            failures++;
            $display("FAIL release: got act=%0b led=%0h expected act=0 led=01", led_act, led);
        end
    endtask

    task automatic test_wrap();
        repeat (3) press_release();
        for (int i = 0; i < 256; i++) begin
            step();
            checks++;
            if ({led_r, led_g, led_b} !== exp_rgb(n_q, 0)) begin
                failures++;
                $display("FAIL wrap4_rgb_red n=%0d: got %b expected %b",
                         n_q, {led_r, led_g, led_b}, exp_rgb(n_q, 0));
            end
        end
        checks++;
        if (led !== 8'h04) begin
            failures++;
            $display("FAIL wrap4_led: got %0h expected 04", led);
        end
        repeat (252) press_release();
        checks++;
        if (led !== 8'h00 || exp_led !== 8'h00) begin
            failures++;
            $display("FAIL wrap256_led: got %0h expected 00", led);
        end
        for (int i = 0; i < 256; i++) begin
            step();
            checks++;
            if ({led_r, led_g, led_b} !== exp_rgb(n_q, 0)) begin
                failures++;
                $display("FAIL wrap256_rgb_red n=%0d: got %b expected %b",
                         n_q, {led_r, led_g, led_b}, exp_rgb(n_q, 0));
            end
        end
    endtask

    task automatic test_slow_toggle();
        logic       hist [0:1023];
        logic       b;
        logic [7:0] base;
        base = exp_led;
        for (int i = 0; i < 1024; i++) begin
            step();
            checks++;
            if (i >= 18) begin
                if (led_act !== ~hist[i-18]) begin
                    failures++;
                    $display("FAIL slow_act i=%0d: got %0b expected %0b", i, led_act, ~hist[i-18]);
                end
            end else if (led_act !== 1'b0) begin
                failures++;
                $display("FAIL slow_act i=%0d: got %0b expected 0", i, led_act);
            end
            b = (((i >> 6) & 1) == 0);
            btn_usr = b;
            hist[i] = b;
        end
        btn_usr = 1'b1;
        repeat (25) step();
        exp_led = base + 8'd8;
        exp_col = (exp_col + 8) % 4;
        checks++;
        if (led !== exp_led) begin
            failures++;
            $display("FAIL slow_led: got %0h expected %0h", led, exp_led);
        end
    endtask

    task automatic test_heartbeat_pwm();
        int   toggles;
        int   last_t;
        int   high_r;
        logic prev;
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_led = 8'h00;
        exp_col = 0;
        toggles = 0;
        last_t  = 0;
        high_r  = 0;
        prev    = 1'b0;
        for (int i = 0; i < 33100; i++) begin
            step();
            if (led_usr !== prev) begin
                toggles++;
                checks++;
                if (int'(n_q) - last_t != 1024) begin
                    failures++;
                    $display("FAIL heartbeat_interval n=%0d: got %0d expected 1024",
                             n_q, int'(n_q) - last_t);
                end
                last_t = int'(n_q);
                prev   = led_usr;
            end
            if (n_q >= 24'h8001 && n_q <= 24'h8100) begin
                if (led_r === 1'b1) high_r++;
                checks++;
                if (led_g !== 1'b0 || led_b !== 1'b0) begin
                    failures++;
                    $display("FAIL pwm_gb_off n=%0d: got g=%0b b=%0b expected 0", n_q, led_g, led_b);
                end
            end
        end
        checks++;
        if (toggles != 32) begin
            failures++;
            $display("FAIL heartbeat_toggles: got %0d expected 32", toggles);
        end
        checks++;
        if (high_r != 128) begin
            failures++;
            $display("FAIL pwm_half_duty: got %0d expected 128", high_r);
        end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_clean_press();
        test_wrap();
        test_slow_toggle();
        test_heartbeat_pwm();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
